// File: rtl/uart_rx.sv
// UART frame receiver: 1 start, 8 data (MSB first), 1 parity, 1 stop bit.
// Checks parity and framing and strobes good bytes into the downstream FIFO.
module uart_rx #(
  parameter int unsigned CLOCKS_PER_BIT = 14,
  parameter int unsigned SAMPLE_POINT   = 6
) (
  input  logic       clk_3125_rx,
  input  logic       rst_n,
  input  logic       parity_type,
  input  logic       rx,
  input  logic       ff_full,
  output logic [7:0] rx_msg,
  output logic       rx_complete,
  output logic       wr_en,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(CLOCKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SAMPLE_CNT = CNT_W'(SAMPLE_POINT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_sync1, r_sync2;
  logic             r_armed, w_armed_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit_idx, w_bit_idx_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_par, w_par_nxt;
  logic [7:0]       r_rx_msg, w_rx_msg_nxt;
  logic             r_complete, w_complete_nxt;
  logic             r_wr_en, w_wr_en_nxt;
  logic             r_parity_err, w_parity_err_nxt;
  logic             r_frame_err, w_frame_err_nxt;
  logic             r_overrun, w_overrun_nxt;
  logic             w_rx_s;
  logic             w_perr, w_ferr;

  assign w_rx_s = r_sync2;
  assign w_perr = r_par != ((^r_shift) ^ parity_type);
  assign w_ferr = ~w_rx_s;

  // State, synchroniser and registered outputs
  always_ff @(posedge clk_3125_rx) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_armed      <= 1'b1;
      r_cnt        <= '0;
      r_bit_idx    <= 3'd7;
      r_shift      <= '0;
      r_par        <= 1'b0;
      r_rx_msg     <= '0;
      r_complete   <= 1'b0;
      r_wr_en      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sync1      <= rx;
      r_sync2      <= r_sync1;
      r_armed      <= w_armed_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_shift      <= w_shift_nxt;
      r_par        <= w_par_nxt;
      r_rx_msg     <= w_rx_msg_nxt;
      r_complete   <= w_complete_nxt;
      r_wr_en      <= w_wr_en_nxt;
      r_parity_err <= w_parity_err_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_armed_nxt      = r_armed;
    w_cnt_nxt        = r_cnt;
    w_bit_idx_nxt    = r_bit_idx;
    w_shift_nxt      = r_shift;
    w_par_nxt        = r_par;
    w_rx_msg_nxt     = r_rx_msg;
    w_complete_nxt   = 1'b0;
    w_wr_en_nxt      = 1'b0;
    w_parity_err_nxt = r_parity_err;
    w_frame_err_nxt  = r_frame_err;
    w_overrun_nxt    = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt     = '0;
        w_bit_idx_nxt = 3'd7;
        if (w_rx_s) begin
          w_armed_nxt = 1'b1;
        end
        // The detection cycle already counts as the first cycle of the start bit
        if (r_armed && !w_rx_s) begin
          w_state_nxt = S_START;
          w_armed_nxt = 1'b0;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      S_START: begin
        if (r_cnt == SAMPLE_CNT) begin
          w_cnt_nxt   = '0;
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (r_cnt == LAST_CNT) begin
          w_shift_nxt[r_bit_idx] = w_rx_s;
          w_cnt_nxt              = '0;
          if (r_bit_idx == 3'd0) begin
            w_state_nxt = S_PARITY;
          end else begin
            w_bit_idx_nxt = r_bit_idx - 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (r_cnt == LAST_CNT) begin
          w_par_nxt   = w_rx_s;
          w_cnt_nxt   = '0;
          w_state_nxt = S_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (r_cnt == LAST_CNT) begin
          w_rx_msg_nxt     = r_shift;
          w_complete_nxt   = 1'b1;
          w_parity_err_nxt = w_perr;
          w_frame_err_nxt  = w_ferr;
          w_wr_en_nxt      = !w_perr && !w_ferr && !ff_full;
          w_overrun_nxt    = !w_perr && !w_ferr && ff_full;
          w_cnt_nxt        = '0;
          w_state_nxt      = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign rx_msg      = r_rx_msg;
  assign rx_complete = r_complete;
  assign wr_en       = r_wr_en;
  assign parity_err  = r_parity_err;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a frame-level model predicts the pulse cycle
// and flags of every frame sent; one compare process checks all outputs each cycle.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n, parity_type, rx, ff_full;
  logic [7:0] rx_msg;
  logic       rx_complete, wr_en, parity_err, frame_err, overrun;

  always #5 clk = ~clk;

  uart_rx dut (
    .clk_3125_rx (clk),
    .rst_n       (rst_n),
    .parity_type (parity_type),
    .rx          (rx),
    .ff_full     (ff_full),
    .rx_msg      (rx_msg),
    .rx_complete (rx_complete),
    .wr_en       (wr_en),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun     (overrun)
  );

  typedef struct {
    int         at;
    logic [7:0] msg;
    bit         perr;
    bit         ferr;
    bit         wr;
    bit         ovr;
  } exp_t;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  exp_t       exp_q[$];
  logic [7:0] m_msg = 8'h00;
  bit         m_perr = 1'b0;
  bit         m_ferr = 1'b0;
  bit         checking = 1'b0;
  bit         rst_seen = 1'b0;
  int         wr_cyc[$];
  int         n_comp = 0;
  int         n_ovr = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !rst_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Per-cycle comparison against the frame-level model
  always @(negedge clk) begin
    bit   due;
    exp_t e;
    if (checking) begin
      if (rst_seen) begin
        exp_q.delete();
        m_msg  = 8'h00;
        m_perr = 1'b0;
        m_ferr = 1'b0;
      end
      due = (exp_q.size() > 0) && (exp_q[0].at == cyc);
      e   = '{at: 0, msg: 8'h00, perr: 1'b0, ferr: 1'b0, wr: 1'b0, ovr: 1'b0};
      if (due) begin
        e      = exp_q.pop_front();
        m_msg  = e.msg;
        m_perr = e.perr;
        m_ferr = e.ferr;
      end
      check("rx_complete", 32'(rx_complete), 32'(due));
      check("wr_en",       32'(wr_en),       32'(due && e.wr));
      check("overrun",     32'(overrun),     32'(due && e.ovr));
      check("rx_msg",      32'(rx_msg),      32'(m_msg));
      check("parity_err",  32'(parity_err),  32'(m_perr));
      check("frame_err",   32'(frame_err),   32'(m_ferr));
    end
  end

  always @(negedge clk) begin
    if (wr_en) wr_cyc.push_back(cyc);
    if (rx_complete) n_comp++;
    if (overrun) n_ovr++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) tick();
  endtask

  // Drives one 154-cycle frame; rst_at >= 0 pulses reset at that cycle offset and aborts
  task automatic send(input logic [7:0] d, input bit ptype, input bit force_par,
                      input bit par_val, input bit stop, input bit full,
                      input int rst_at, output int t0);
    logic [10:0] bits;
    bit          par;
    exp_t        e;
    parity_type = ptype;
    ff_full     = full;
    par  = force_par ? par_val : ((^d) ^ ptype);
    bits = {1'b0, d, par, stop};
    t0   = cyc + 1;
    if (rst_at < 0) begin
      e.at   = t0 + 148;
      e.msg  = d;
      e.perr = (par != ((^d) ^ ptype));
      e.ferr = !stop;
      e.wr   = !e.perr && !e.ferr && !full;
      e.ovr  = !e.perr && !e.ferr && full;
      exp_q.push_back(e);
    end
    for (int i = 0; i < 154; i++) begin
      rx = bits[10 - i/14];
      if (i == rst_at) rst_n = 1'b0;
      tick();
      if (i == rst_at) begin
        check("mid-frame reset rx_msg", 32'(rx_msg), 32'h0);
        check("mid-frame reset pulses/flags",
              32'({rx_complete, wr_en, parity_err, frame_err, overrun}), 32'h0);
        rst_n = 1'b1;
        rx    = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    int n, t0, c0, o0;
    rst_n = 1'b0;
    rx = 1'b1;
    parity_type = 1'b0;
    ff_full = 1'b0;
    repeat (3) tick();
    check("reset rx_msg", 32'(rx_msg), 32'h0);
    check("reset pulses/flags",
          32'({rx_complete, wr_en, parity_err, frame_err, overrun}), 32'h0);
    rst_n = 1'b1;
    checking = 1'b1;
    idle(5);

    // Good frame, even parity
    n = wr_cyc.size();
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, t0);
    idle(4);
    check("A5 wr_en latency", 32'((wr_cyc.size() > n) ? wr_cyc[n] - t0 : -1), 32'd148);
    check("A5 rx_msg", 32'(rx_msg), 32'hA5);
    check("A5 no errors", 32'({parity_err, frame_err}), 32'h0);

    // Parity error: odd parity expected 1, sent 0
    n = wr_cyc.size();
    send(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1, t0);
    idle(4);
    check("3C parity_err", 32'(parity_err), 32'h1);
    check("3C no wr_en", 32'(wr_cyc.size()), 32'(n));

    // Framing error followed by a 300-cycle break
    n  = wr_cyc.size();
    c0 = n_comp;
    send(8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, t0);
    rx = 1'b0;
    repeat (300) tick();
    check("break single complete", 32'(n_comp), 32'(c0 + 1));
    check("break frame_err", 32'(frame_err), 32'h1);
    check("break no wr_en", 32'(wr_cyc.size()), 32'(n));
    idle(30);

    // 4-cycle glitch is rejected
    c0 = n_comp;
    rx = 1'b0;
    repeat (4) tick();
    idle(20);
    check("glitch no complete", 32'(n_comp), 32'(c0));

    // Overrun with FIFO full
    n  = wr_cyc.size();
    o0 = n_ovr;
    send(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, -1, t0);
    idle(4);
    ff_full = 1'b0;
    check("55 overrun pulse", 32'(n_ovr), 32'(o0 + 1));
    check("55 rx_msg", 32'(rx_msg), 32'h55);
    check("55 no wr_en", 32'(wr_cyc.size()), 32'(n));

    // Back-to-back frames, 2 idle cycles apart
    n = wr_cyc.size();
    send(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, t0);
    idle(2);
    send(8'hEF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, t0);
    check("b2b wr_en spacing",
          32'((wr_cyc.size() >= n + 2) ? wr_cyc[n+1] - wr_cyc[n] : -1), 32'd156);

    // Zero-gap frames
    n = wr_cyc.size();
    send(8'h96, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, t0);
    send(8'h69, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, t0);
    idle(4);
    check("zero-gap wr_en count", 32'(wr_cyc.size()), 32'(n + 2));
    check("zero-gap rx_msg", 32'(rx_msg), 32'h69);

    // Reset in the middle of a frame, then a clean frame
    n = wr_cyc.size();
    send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 60, t0);
    idle(20);
    send(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1, t0);
    idle(4);
    check("post-reset rx_msg", 32'(rx_msg), 32'hC3);
    check("post-reset single write", 32'(wr_cyc.size()), 32'(n + 1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
